// File: rtl/sb_config_loader.sv
// rtl/sb_config_loader.sv - switch box configuration loader
// Streams a header plus (address, data) pairs into one-hot config_en strobes.
module sb_config_loader #(
  parameter int          NUM_SB = 16,
  parameter int          DATA_W = 32,
  parameter logic [15:0] MAGIC  = 16'hC0F1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              err_clr,
  output logic [DATA_W-1:0] config_data,
  output logic [NUM_SB-1:0] config_en,
  output logic              busy,
  output logic              done,
  output logic              err_header,
  output logic              err_addr,
  output logic [15:0]       write_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       cnt;
  logic [DATA_W-1:0] addr_q;
  logic              xfer;
  logic              addr_ok;
  logic              hdr_ok;
  logic              hdr_zero;
  logic              do_write;
  logic              do_skip;
  logic [NUM_SB-1:0] en_nxt;

  assign in_ready = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
  assign xfer     = in_valid & in_ready;
  assign hdr_ok   = (in_data[31:16] == MAGIC);
  assign hdr_zero = (in_data[15:0] == 16'd0);
  assign addr_ok  = (addr_q < DATA_W'(NUM_SB));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (xfer) begin
          if (!hdr_ok)       state_nxt = S_ERR;
          else if (hdr_zero) state_nxt = S_DONE;
          else               state_nxt = S_ADDR;
        end
      end
      S_ADDR:  if (xfer) state_nxt = S_DATA;
      S_DATA:  if (xfer) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (cnt == 16'd1) ? S_DONE : S_ADDR;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   if (err_clr) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The strobe is registered on the DATA handshake so it is live exactly during WRITE.
  always_comb begin
    do_write = (state == S_DATA) && xfer && addr_ok;
    do_skip  = (state == S_DATA) && xfer && !addr_ok;
    en_nxt   = '0;
    if (do_write) begin
      for (int i = 0; i < NUM_SB; i++) begin
        en_nxt[i] = (addr_q == DATA_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      addr_q      <= '0;
      config_en   <= '0;
      config_data <= '0;
      write_count <= '0;
      err_addr    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_header  <= 1'b0;
    end else begin
      config_en  <= en_nxt;
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
      err_header <= (state_nxt == S_ERR);
      if (state == S_IDLE && xfer && hdr_ok && !hdr_zero) begin
        cnt         <= in_data[15:0];
        write_count <= '0;
        err_addr    <= 1'b0;
      end
      if (state == S_ADDR && xfer) begin
        addr_q <= in_data;
      end
      if (do_write) begin
        config_data <= in_data;
        if (write_count != 16'hFFFF) begin
          write_count <= write_count + 16'd1;
        end
      end
      if (do_skip) begin
        err_addr <= 1'b1;
      end
      if (state == S_WRITE) begin
        cnt <= cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sb_config_loader.sv
// tb/tb_sb_config_loader.sv - directed bench for sb_config_loader
module tb_sb_config_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        err_clr;
  logic [31:0] config_data;
  logic [15:0] config_en;
  logic        busy;
  logic        done;
  logic        err_header;
  logic        err_addr;
  logic [15:0] write_count;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int onehot_err = 0;
  logic [47:0] log_q[$];

  sb_config_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .err_clr(err_clr), .config_data(config_data),
    .config_en(config_en), .busy(busy), .done(done), .err_header(err_header),
    .err_addr(err_addr), .write_count(write_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (config_en != 16'd0) log_q.push_back({config_en, config_data});
      if ($countones(config_en) > 1) onehot_err++;
      if (done) done_cnt++;
    end
  end

  task automatic send_word(input logic [31:0] w, input int gap);
    bit ok = 0;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_word timeout word=%h in_ready=%b required 1", w, in_ready);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    n_cmp++;
    if ({config_en, config_data, write_count, busy, done, err_header, err_addr} !== 68'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got en=%h data=%h wc=%h busy=%b done=%b eh=%b ea=%b required all 0",
               config_en, config_data, write_count, busy, done, err_header, err_addr);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
  endtask

  task automatic test_basic_load();
    clear_log();
    send_word(32'hC0F1_0002, 0);
    send_word(32'd3, 0);
    send_word(32'hDEADBEEF, 0);
    n_cmp++;
    if (config_en !== 16'h0008 || config_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL strobe_latency got en=%h data=%h required 0008/deadbeef", config_en, config_data);
    end
    send_word(32'd0, 0);
    send_word(32'h0000_0155, 0);
    idle(4);
    n_cmp++;
    if (log_q.size() != 2) begin
      n_bad++; $display("FAIL basic_strobe_count got %0d required 2", log_q.size());
    end else begin
      n_cmp++;
      if (log_q[0] !== {16'h0008, 32'hDEADBEEF} || log_q[1] !== {16'h0001, 32'h0000_0155}) begin
        n_bad++; $display("FAIL basic_strobes got %h %h required 0008deadbeef 000100000155", log_q[0], log_q[1]);
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done got %0d pulses required 1", done_cnt); end
    n_cmp++;
    if (write_count !== 16'd2 || err_addr !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_status got wc=%0d ea=%b busy=%b required 2/0/0", write_count, err_addr, busy);
    end
  endtask

  task automatic test_bad_addr();
    clear_log();
    send_word(32'hC0F1_0001, 0);
    send_word(32'd16, 0);
    send_word(32'h1234_5678, 0);
    idle(4);
    n_cmp++;
    if (log_q.size() != 0) begin n_bad++; $display("FAIL badaddr_strobes got %0d required 0", log_q.size()); end
    n_cmp++;
    if (err_addr !== 1'b1 || write_count !== 16'd0 || done_cnt != 1) begin
      n_bad++; $display("FAIL badaddr_status got ea=%b wc=%0d done=%0d required 1/0/1", err_addr, write_count, done_cnt);
    end
    n_cmp++;
    if (config_data !== 32'h0000_0155) begin
      n_bad++; $display("FAIL badaddr_data_hold got %h required 00000155", config_data);
    end
  endtask

  task automatic test_bad_header();
    clear_log();
    send_word(32'h1234_0001, 0);
    n_cmp++;
    if (err_header !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL hdr_err got eh=%b rdy=%b busy=%b required 1/0/1", err_header, in_ready, busy);
    end
    idle(3);
    n_cmp++;
    if (err_header !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL hdr_err_hold got eh=%b rdy=%b required 1/0", err_header, in_ready);
    end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    n_cmp++;
    if (err_header !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL hdr_clr got eh=%b rdy=%b busy=%b required 0/1/0", err_header, in_ready, busy);
    end
    send_word(32'hC0F1_0001, 0);
    send_word(32'd5, 0);
    send_word(32'hA5A5_A5A5, 0);
    idle(4);
    n_cmp++;
    if (log_q.size() != 1 || write_count !== 16'd1 || err_addr !== 1'b0 || done_cnt != 1) begin
      n_bad++; $display("FAIL hdr_recover got n=%0d wc=%0d ea=%b done=%0d required 1/1/0/1",
                        log_q.size(), write_count, err_addr, done_cnt);
    end else begin
      n_cmp++;
      if (log_q[0] !== {16'h0020, 32'hA5A5_A5A5}) begin
        n_bad++; $display("FAIL hdr_recover_strobe got %h required 0020a5a5a5a5", log_q[0]);
      end
    end
  endtask

  task automatic test_zero_pairs();
    clear_log();
    send_word(32'hC0F1_0000, 0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL zero_done got done=%b busy=%b required 1/1", done, busy);
    end
    idle(1);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_after got done=%b busy=%b required 0/0", done, busy);
    end
    idle(2);
    n_cmp++;
    if (log_q.size() != 0 || done_cnt != 1) begin
      n_bad++; $display("FAIL zero_strobes got n=%0d done=%0d required 0/1", log_q.size(), done_cnt);
    end
  endtask

  task automatic test_stalled_load();
    logic [31:0] addrs[4];
    logic [31:0] datas[4];
    logic [15:0] ens[4];
    addrs = '{32'd15, 32'd2, 32'd7, 32'd15};
    datas = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    ens   = '{16'h8000, 16'h0004, 16'h0080, 16'h8000};
    clear_log();
    onehot_err = 0;
    send_word(32'hC0F1_0004, $urandom_range(0, 3));
    for (int p = 0; p < 4; p++) begin
      send_word(addrs[p], $urandom_range(0, 3));
      send_word(datas[p], $urandom_range(0, 3));
    end
    idle(4);
    n_cmp++;
    if (log_q.size() != 4) begin
      n_bad++; $display("FAIL stall_strobe_count got %0d required 4", log_q.size());
    end else begin
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (log_q[p] !== {ens[p], datas[p]}) begin
          n_bad++; $display("FAIL stall_strobe%0d got %h required %h", p, log_q[p], {ens[p], datas[p]});
        end
      end
    end
    n_cmp++;
    if (onehot_err != 0 || write_count !== 16'd4 || done_cnt != 1) begin
      n_bad++; $display("FAIL stall_status got onehot_err=%0d wc=%0d done=%0d required 0/4/1",
                        onehot_err, write_count, done_cnt);
    end
  endtask

  task automatic test_reset_mid_pair();
    clear_log();
    send_word(32'hC0F1_0003, 0);
    send_word(32'd1, 0);
    send_word(32'h0000_AAAA, 0);
    send_word(32'd4, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    n_cmp++;
    if ({config_en, config_data, write_count, busy, done, err_header, err_addr} !== 68'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_outputs got en=%h data=%h wc=%h busy=%b done=%b eh=%b ea=%b rdy=%b required 0s and rdy=1",
               config_en, config_data, write_count, busy, done, err_header, err_addr, in_ready);
    end
    idle(3);
    n_cmp++;
    if (log_q.size() != 1) begin n_bad++; $display("FAIL midreset_strobes got %0d required 1", log_q.size()); end
    send_word(32'hC0F1_0001, 0);
    send_word(32'd9, 0);
    send_word(32'h0000_0099, 0);
    idle(4);
    n_cmp++;
    if (log_q.size() != 2 || write_count !== 16'd1 || done_cnt != 1) begin
      n_bad++; $display("FAIL midreset_reload got n=%0d wc=%0d done=%0d required 2/1/1", log_q.size(), write_count, done_cnt);
    end else begin
      n_cmp++;
      if (log_q[1] !== {16'h0200, 32'h0000_0099}) begin
        n_bad++; $display("FAIL midreset_reload_strobe got %h required 020000000099", log_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_addr();
    test_bad_header();
    test_zero_pairs();
    test_stalled_load();
    test_reset_mid_pair();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
